seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the team's 4-bit combinational calculator ALU.
- Performs unsigned add, subtract, multiply and divide on W-bit operands.
- Handles start/busy/done handshaking.
- Multiply and divide run iteratively (shift-add and restoring divide), one bit per clock, so the block scales to wide operands without a large combinational array.
- Sits between the calculator's operand/keypad capture logic and its result display.

---
 rtl/seq_alu.sv | 253 +++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle unsigned add/sub/mul/div with start/busy/done handshake.
// Multiply is shift-add (multiplier LSB first); divide is restoring (MSB first).
// Both run one bit per clock after a single setup cycle.
// Optional feature macro: SEQ_ALU_REM_EN adds the registered `rem` output
// carrying the division remainder (i1 on divide-by-zero).
module seq_alu #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [1:0]     ctrl,
    input  logic [W-1:0]   i1,
    input  logic [W-1:0]   i2,
    output logic [2*W-1:0] o,
    output logic           busy,
    output logic           done,
    output logic           err
`ifdef SEQ_ALU_REM_EN
    ,
    output logic [W-1:0]   rem
`endif
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Latched request
    op_t             r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;

    // Iteration control: r_setup marks the first RUN cycle
    logic            r_setup;
    logic [CW-1:0]   r_cnt;

    // Multiply datapath
    logic [2*W-1:0]  r_prod;
    logic [2*W-1:0]  r_mcand;
    logic [W-1:0]    r_mpl;

    // Divide datapath (quotient shifts in where the dividend shifts out)
    logic [W-1:0]    r_q;
    logic [W-1:0]    r_drem;

    // Output registers
    logic [2*W-1:0]  r_o;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
`ifdef SEQ_ALU_REM_EN
    logic [W-1:0]    r_rem;
`endif

    logic            w_accept;
    logic            w_div0;
    logic            w_short;
    logic            w_fin;
    logic [2*W-1:0]  w_mul_prod;
    logic [W:0]      w_div_shift;
    logic [W:0]      w_div_diff;
    logic            w_div_ge;
    logic [W-1:0]    w_div_rem;
    logic [W-1:0]    w_div_q;
    logic [2*W-1:0]  w_res;
    logic [W-1:0]    w_rem_nxt;

    assign o    = r_o;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
`ifdef SEQ_ALU_REM_EN
    assign rem  = r_rem;
`endif

    // One iteration step of the shift-add multiplier and restoring divider
    always_comb begin
        w_mul_prod  = {(2*W){1'b0}};
        w_div_shift = {(W+1){1'b0}};
        w_div_diff  = {(W+1){1'b0}};
        w_div_ge    = 1'b0;
        w_div_rem   = {W{1'b0}};
        w_div_q     = {W{1'b0}};
        if (r_mpl[0]) begin
            w_mul_prod = r_prod + r_mcand;
        end else begin
            w_mul_prod = r_prod;
        end
        w_div_shift = {r_drem, r_q[W-1]};
        w_div_diff  = w_div_shift - {1'b0, r_b};
        // Partial remainder < divisor, so the difference fits W+1 bits signed
        w_div_ge    = ~w_div_diff[W];
        if (w_div_ge) begin
            w_div_rem = w_div_diff[W-1:0];
        end else begin
            w_div_rem = w_div_shift[W-1:0];
        end
        w_div_q = {r_q[W-2:0], w_div_ge};
    end

    // Completion detection, next state and result selection
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_div0      = 1'b0;
        w_short     = 1'b0;
        w_fin       = 1'b0;
        w_res       = {(2*W){1'b0}};
        w_rem_nxt   = {W{1'b0}};

        w_div0  = (r_op == OP_DIV) && (r_b == {W{1'b0}});
        w_short = (r_op == OP_ADD) || (r_op == OP_SUB) || w_div0;

        case (r_state)
            IDLE: begin
                w_accept = start;
                if (start) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (r_setup) begin
                    w_fin = w_short;
                end else begin
                    w_fin = (r_cnt == {CW{1'b0}});
                end
                if (w_fin) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        case (r_op)
            OP_ADD:  w_res = {{W{1'b0}}, r_a} + {{W{1'b0}}, r_b};
            OP_SUB:  w_res = {{W{1'b0}}, r_a} - {{W{1'b0}}, r_b};
            OP_MUL:  w_res = w_mul_prod;
            OP_DIV: begin
                if (w_div0) begin
                    w_res = {(2*W){1'b1}};
                end else begin
                    w_res = {{W{1'b0}}, w_div_q};
                end
            end
            default: w_res = {(2*W){1'b0}};
        endcase

        if (w_div0) begin
            w_rem_nxt = r_a;
        end else begin
            w_rem_nxt = w_div_rem;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latch, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= OP_ADD;
            r_a     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_setup <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_prod  <= {(2*W){1'b0}};
            r_mcand <= {(2*W){1'b0}};
            r_mpl   <= {W{1'b0}};
            r_q     <= {W{1'b0}};
            r_drem  <= {W{1'b0}};
            r_o     <= {(2*W){1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef SEQ_ALU_REM_EN
            r_rem   <= {W{1'b0}};
`endif
        end else begin
            r_done <= w_fin;
            r_busy <= (w_state_nxt == RUN);
            if (w_accept) begin
                r_op    <= op_t'(ctrl);
                r_a     <= i1;
                r_b     <= i2;
                r_setup <= 1'b1;
            end else if (r_state == RUN) begin
                if (r_setup) begin
                    r_setup <= 1'b0;
                    r_prod  <= {(2*W){1'b0}};
                    r_mcand <= {{W{1'b0}}, r_a};
                    r_mpl   <= r_b;
                    r_q     <= r_a;
                    r_drem  <= {W{1'b0}};
                    r_cnt   <= CW'(W - 1);
                end else begin
                    r_prod  <= w_mul_prod;
                    r_mcand <= {r_mcand[2*W-2:0], 1'b0};
                    r_mpl   <= {1'b0, r_mpl[W-1:1]};
                    r_q     <= w_div_q;
                    r_drem  <= w_div_rem;
                    if (r_cnt != {CW{1'b0}}) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                if (w_fin) begin
                    r_o   <= w_res;
                    r_err <= w_div0;
`ifdef SEQ_ALU_REM_EN
                    if (r_op == OP_DIV) begin
                        r_rem <= w_rem_nxt;
                    end else begin
                        r_rem <= r_rem;
                    end
`endif
                end else begin
                    r_o   <= r_o;
                    r_err <= r_err;
                end
            end else begin
                r_setup <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (W=4).
// Define SEQ_ALU_REM_EN for both files to also check the remainder port.
module tb_seq_alu;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] ctrl;
    logic [3:0] i1;
    logic [3:0] i2;
    logic [7:0] o;
    logic       busy;
    logic       done;
    logic       err;
`ifdef SEQ_ALU_REM_EN
    logic [3:0] rem;
`endif

    int n_tests;
    int n_fail;

    seq_alu #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ctrl  (ctrl),
        .i1    (i1),
        .i2    (i2),
        .o     (o),
        .busy  (busy),
        .done  (done),
`ifdef SEQ_ALU_REM_EN
        .err   (err),
        .rem   (rem)
`else
        .err   (err)
`endif
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, optionally poke start while busy, and check timing + results
    task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp_o, input logic exp_err, input logic [3:0] exp_rem,
                          input int exp_lat, input bit poke, input string tag);
        int lat;
        @(negedge clk);
        ctrl  = op;
        i1    = a;
        i2    = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        i1    = ~a;
        i2    = ~b;
        ctrl  = ~op;
        check({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
        check({tag, "_done_after_accept"}, {31'd0, done}, 32'd0);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (poke && lat == 1) begin
                start = 1'b1;
                ctrl  = 2'b00;
                i1    = 4'd1;
                i2    = 4'd1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_o"}, {24'd0, o}, {24'd0, exp_o});
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
`ifdef SEQ_ALU_REM_EN
        if (op == 2'b11) begin
            check({tag, "_rem"}, {28'd0, rem}, {28'd0, exp_rem});
        end
`else
        if (exp_rem != exp_rem) begin
            n_fail++;
        end
`endif
        @(posedge clk);
        #1;
        check({tag, "_done_pulse_end"}, {31'd0, done}, 32'd0);
        check({tag, "_o_hold"}, {24'd0, o}, {24'd0, exp_o});
    endtask

    initial begin
        int  lat;
        bit  seen;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        ctrl    = 2'b00;
        i1      = 4'd0;
        i2      = 4'd0;

        // Reset state before any clock edge
        #2;
        check("reset_o", {24'd0, o}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
`ifdef SEQ_ALU_REM_EN
        check("reset_rem", {28'd0, rem}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // add / sub, L=1
        run_op(2'b00, 4'd6,  4'd2,  8'h08, 1'b0, 4'd0, 1, 1'b0, "add_6_2");
        run_op(2'b00, 4'd15, 4'd15, 8'h1E, 1'b0, 4'd0, 1, 1'b0, "add_15_15");
        run_op(2'b01, 4'd6,  4'd2,  8'h04, 1'b0, 4'd0, 1, 1'b0, "sub_6_2");
        run_op(2'b01, 4'd2,  4'd6,  8'hFC, 1'b0, 4'd0, 1, 1'b0, "sub_2_6");
        run_op(2'b01, 4'd0,  4'd15, 8'hF1, 1'b0, 4'd0, 1, 1'b0, "sub_0_15");

        // mul, L=W+1=5
        run_op(2'b10, 4'd15, 4'd15, 8'hE1, 1'b0, 4'd0, 5, 1'b0, "mul_15_15");
        run_op(2'b10, 4'd6,  4'd2,  8'h0C, 1'b0, 4'd0, 5, 1'b0, "mul_6_2");
        run_op(2'b10, 4'd0,  4'd9,  8'h00, 1'b0, 4'd0, 5, 1'b0, "mul_0_9");

        // div
        run_op(2'b11, 4'd6,  4'd2,  8'h03, 1'b0, 4'd0, 5, 1'b0, "div_6_2");
        run_op(2'b11, 4'd7,  4'd2,  8'h03, 1'b0, 4'd1, 5, 1'b0, "div_7_2");
        run_op(2'b11, 4'd2,  4'd7,  8'h00, 1'b0, 4'd2, 5, 1'b0, "div_2_7");
        run_op(2'b11, 4'd15, 4'd1,  8'h0F, 1'b0, 4'd0, 5, 1'b0, "div_15_1");
        run_op(2'b11, 4'd9,  4'd0,  8'hFF, 1'b1, 4'd9, 1, 1'b0, "div_9_0");
        run_op(2'b11, 4'd7,  4'd2,  8'h03, 1'b0, 4'd1, 5, 1'b0, "div_clears_err");

        // start while busy is ignored
        run_op(2'b10, 4'd15, 4'd15, 8'hE1, 1'b0, 4'd0, 5, 1'b1, "mul_busy_poke");

        // Back-to-back: new op accepted in the done cycle
        @(negedge clk);
        ctrl  = 2'b10;
        i1    = 4'd6;
        i2    = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_mul_latency", lat, 32'd5);
        check("b2b_mul_o", {24'd0, o}, 32'h0C);
        ctrl  = 2'b00;
        i1    = 4'd6;
        i2    = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_gap_done", {31'd0, done}, 32'd0);
        check("b2b_gap_busy", {31'd0, busy}, 32'd1);
        check("b2b_gap_o_hold", {24'd0, o}, 32'h0C);
        @(posedge clk);
        #1;
        check("b2b_add_done", {31'd0, done}, 32'd1);
        check("b2b_add_o", {24'd0, o}, 32'h08);
        check("b2b_add_busy", {31'd0, busy}, 32'd0);

        // Leave err=1 so reset has something to clear
        run_op(2'b11, 4'd9, 4'd0, 8'hFF, 1'b1, 4'd9, 1, 1'b0, "div_9_0_again");

        // Reset mid-way through mul 15*15
        @(negedge clk);
        ctrl  = 2'b10;
        i1    = 4'd15;
        i2    = 4'd15;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_o", {24'd0, o}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
`ifdef SEQ_ALU_REM_EN
        check("midrst_rem", {28'd0, rem}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) begin
                seen = 1'b1;
            end
        end
        check("midrst_no_done_after", {31'd0, seen}, 32'd0);
        run_op(2'b11, 4'd6, 4'd2, 8'h03, 1'b0, 4'd0, 5, 1'b0, "div_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
